// File: rtl/instr_sequencer.sv
// Multi-cycle control sequencer for a three-instruction subset (ADD, LW, SW).
// Walks FETCH/DECODE/EXEC/MEM/WB and counts retired instructions.
module instr_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        halt_req,
    input  logic [5:0]  opcode,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        ir_load,
    output logic        pc_en,
    output logic        we_reg,
    output logic        we_mem,
    output logic        mem_read,
    output logic [2:0]  alu_control,
    output logic [2:0]  state,
    output logic        illegal,
    output logic [15:0] instr_count
);

    localparam logic [5:0] OP_ADD = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [2:0] ALU_ADD = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [5:0]  op_q;
    logic        illegal_q;
    logic [15:0] cnt_q;
    logic        retire;
    logic        set_ill;
    logic        clr_ill;

    logic dec_add;
    logic dec_lw;
    logic dec_sw;
    logic q_add;
    logic q_lw;
    logic q_sw;

    assign dec_add = (opcode == OP_ADD);
    assign dec_lw  = (opcode == OP_LW);
    assign dec_sw  = (opcode == OP_SW);
    assign q_add   = (op_q == OP_ADD);
    assign q_lw    = (op_q == OP_LW);
    assign q_sw    = (op_q == OP_SW);

    assign state       = state_q;
    assign illegal     = illegal_q;
    assign instr_count = cnt_q;

    always_comb begin
        state_d     = state_q;
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        ir_load     = 1'b0;
        pc_en       = 1'b0;
        we_reg      = 1'b0;
        we_mem      = 1'b0;
        mem_read    = 1'b0;
        alu_control = 3'b000;
        retire      = 1'b0;
        set_ill     = 1'b0;
        clr_ill     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !halt_req) begin
                    state_d = S_FETCH;
                    clr_ill = 1'b1;
                end
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_load = 1'b1;
                    pc_en   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                unique case (1'b1)
                    dec_add, dec_lw, dec_sw: state_d = S_EXEC;
                    default: begin
                        set_ill = 1'b1;
                        state_d = halt_req ? S_IDLE : S_FETCH;
                    end
                endcase
            end
            S_EXEC: begin
                alu_control = ALU_ADD;
                state_d     = q_add ? S_WB : S_MEM;
            end
            S_MEM: begin
                dmem_req = 1'b1;
                mem_read = q_lw;
                we_mem   = q_sw;
                if (dmem_ready) begin
                    if (q_lw) state_d = S_WB;
                    else      retire  = 1'b1;
                end
            end
            S_WB: begin
                we_reg = 1'b1;
                retire = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        // Every retire point shares the same halt-or-continue decision
        if (retire) state_d = halt_req ? S_IDLE : S_FETCH;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) op_q <= opcode;
            if (clr_ill)      illegal_q <= 1'b0;
            else if (set_ill) illegal_q <= 1'b1;
            if (retire) cnt_q <= cnt_q + 16'd1;
        end
    end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL provide ports: `clk`, in, 1, sole clock; all state updates on the rising edge.
REQ-002 SHALL provide `rst_n`, in, 1: reset, asynchronous and active-low.
REQ-003 SHALL provide `start`, in, 1: leave IDLE and begin fetching.
REQ-004 SHALL provide `halt_req`, in, 1: return to IDLE at the next retire point.
REQ-005 SHALL provide `opcode`, in, 6: instruction opcode field, valid in DECODE.
REQ-006 SHALL provide `imem_ready`, in, 1 and `dmem_ready`, in, 1: instruction/data memory completion strobes.
REQ-007 SHALL provide `imem_req`, out, 1 and `dmem_req`, out, 1: memory access requests.
REQ-008 SHALL provide `ir_load`, out, 1 and `pc_en`, out, 1: IR capture and PC advance strobes.
REQ-009 SHALL provide `we_reg`, out, 1; `we_mem`, out, 1; `mem_read`, out, 1: register/memory write enables and memory read enable.
REQ-010 SHALL provide `alu_control`, out, 3: ALU operation code.
REQ-011 SHALL provide `state`, out, 3: current FSM state encoding.
REQ-012 SHALL provide `illegal`, out, 1: sticky illegal-opcode flag.
REQ-013 SHALL provide `instr_count`, out, 16: count of retired instructions.

Function
REQ-014 SHALL implement states IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5; encodings 6–7 SHALL go to IDLE on the next edge.
REQ-015 IDLE: `start`=1 and `halt_req`=0 -> FETCH and clear `illegal`; otherwise remain IDLE.
REQ-016 FETCH: `imem_req`=1 held while in FETCH; on the cycle `imem_ready`=1, `ir_load`=1 and `pc_en`=1 (combinational with `imem_ready`), then -> DECODE; otherwise stay.
REQ-017 DECODE: SHALL capture `opcode` into an internal register `op_q`; all later states use `op_q`, never live `opcode`.
REQ-018 DECODE with legal opcode 6'b000000 (ADD), 6'b100011 (LW) or 6'b101011 (SW) -> EXEC.
REQ-019 DECODE with any other opcode: set `illegal`, do not retire or increment the count, -> FETCH (or IDLE if `halt_req`=1).
REQ-020 EXEC: `alu_control`=3'b010 for all legal opcodes; ADD -> WB; LW or SW -> MEM.
REQ-021 MEM: `dmem_req`=1; `mem_read`=1 for LW; `we_mem`=1 for SW; held until `dmem_ready`=1. On ready, LW -> WB and SW retires.
REQ-022 WB: `we_reg`=1 for exactly one cycle, then retire.
REQ-023 Retire SHALL increment `instr_count` by 1, modulo 2^16 (16'hFFFF -> 16'h0000), then -> FETCH, or -> IDLE if `halt_req`=1 in that cycle.
REQ-024 `alu_control` SHALL be 3'b000 and every enable/request SHALL be 0 in any state or cycle not listed above.
REQ-025 Zero-wait latency, FETCH entry to retire: ADD 4 cycles, SW 4 cycles, LW 5 cycles; each ready wait cycle adds 1 cycle.
REQ-026 `halt_req` outside DECODE and retire cycles SHALL be ignored; an in-flight instruction always completes.
REQ-027 `imem_ready`/`dmem_ready` asserted in a state that does not request that memory SHALL be ignored.

Reset
REQ-028 `rst_n`=0 SHALL immediately force state=IDLE, `op_q`=0, `illegal`=0, `instr_count`=0, and all outputs low, including mid-access.
REQ-029 After deassertion, the FSM SHALL wait in IDLE for `start`; no memory request is issued before it.

Verification
REQ-030 Reset, then `start` pulse, opcode 000000, both readys tied 1 -> states 1,2,3,5,1; `we_reg` high 1 cycle; `instr_count`=1 after 4 cycles.
REQ-031 LW with `dmem_ready` delayed 3 cycles -> `dmem_req`/`mem_read` high 4 cycles, then WB with `we_reg`=1; retire at cycle 8.
REQ-032 SW, then opcode 6'b111111 -> SW retires with `we_mem` pulse; illegal opcode sets `illegal`=1, returns to FETCH, count unchanged.
REQ-033 `instr_count` preloaded to 16'hFFFF via 65535 ADDs (or force), one more ADD -> 16'h0000.
REQ-034 `halt_req`=1 during MEM of LW -> LW completes through WB, then state=IDLE; `start` with `halt_req`=1 stays IDLE.
REQ-035 `rst_n` pulled low during MEM with `dmem_req`=1 -> same-cycle `dmem_req`=0, state=0, count=0.
